// File: rtl/xperiph_bridge.sv
// Memory-mapped bridge from the controller bus to NSLV peripheral windows,
// with per-slave wait states, bounded timeout and a sticky fault trap.
module xperiph_bridge #(
  parameter int unsigned          DATA_W = 32,
  parameter int unsigned          ADDR_W = 12,
  parameter int unsigned          NSLV   = 8,
  parameter int unsigned          SLV_AW = 4,
  parameter logic [ADDR_W-1:0]    BASE   = 12'h100,
  parameter int unsigned          TO_CYC = 15
) (
  input  logic                     clk50,
  input  logic                     rst,
  input  logic                     m_req,
  input  logic                     m_we,
  input  logic [ADDR_W-1:0]        m_addr,
  input  logic [DATA_W-1:0]        m_wdata,
  output logic [DATA_W-1:0]        m_rdata,
  output logic                     m_ack,
  output logic                     m_err,
  output logic [NSLV-1:0]          s_sel,
  output logic                     s_we,
  output logic [SLV_AW-1:0]        s_addr,
  output logic [DATA_W-1:0]        s_wdata,
  input  logic [NSLV*DATA_W-1:0]   s_rdata,
  input  logic [NSLV-1:0]          s_ack,
  output logic                     trap,
  output logic [ADDR_W-1:0]        err_addr
);

  localparam int unsigned IDX_W     = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int unsigned WIN_WORDS = NSLV << SLV_AW;
  localparam int unsigned CNT_W     = 8;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                trap_q, trap_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

  // Modular subtraction makes addresses below BASE wrap high and miss.
  logic [ADDR_W-1:0]   off;
  logic                hit;
  logic [IDX_W-1:0]    req_idx;
  logic                sel_ack;
  logic [DATA_W-1:0]   sel_rdata;

  assign off       = m_addr - BASE;
  assign hit       = 32'(off) < WIN_WORDS;
  assign req_idx   = IDX_W'(off >> SLV_AW);
  assign sel_ack   = s_ack[idx_q];
  assign sel_rdata = s_rdata[idx_q*DATA_W +: DATA_W];

  always_ff @(posedge clk50) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      trap_q     <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      trap_q     <= trap_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    trap_d     = trap_q;
    err_addr_d = err_addr_q;
    case (state_q)
      IDLE: begin
        if (m_req) begin
          we_d    = m_we;
          addr_d  = m_addr;
          wdata_d = m_wdata;
          idx_d   = req_idx;
          if (hit) begin
            state_d = ACCESS;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = ERR;
            rdata_d = '1;
          end
        end
      end
      ACCESS: begin
        // An acknowledge in the final allowed cycle beats the timeout.
        if (sel_ack) begin
          state_d = DONE;
          rdata_d = we_q ? '0 : sel_rdata;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TO_CYC)) begin
          state_d = ERR;
          rdata_d = '1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      ERR: begin
        state_d = IDLE;
        if (!trap_q) begin
          trap_d     = 1'b1;
          err_addr_d = addr_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_sel = '0;
    m_ack = 1'b0;
    m_err = 1'b0;
    case (state_q)
      ACCESS: s_sel[idx_q] = 1'b1;
      DONE:   m_ack = 1'b1;
      ERR: begin
        m_ack = 1'b1;
        m_err = 1'b1;
      end
      default: ;
    endcase
  end

  assign m_rdata  = rdata_q;
  assign s_we     = we_q;
  assign s_addr   = addr_q[SLV_AW-1:0];
  assign s_wdata  = wdata_q;
  assign trap     = trap_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_xperiph_bridge.sv
// Scoreboard bench for xperiph_bridge: directed accesses with a per-cycle
// slave responder, expected completions queued at request time.
`timescale 1ns/1ps
module tb_xperiph_bridge;

  logic          clk50 = 1'b0;
  logic          rst = 1'b1;
  logic          m_req = 1'b0;
  logic          m_we = 1'b0;
  logic [11:0]   m_addr = '0;
  logic [31:0]   m_wdata = '0;
  logic [31:0]   m_rdata;
  logic          m_ack;
  logic          m_err;
  logic [7:0]    s_sel;
  logic          s_we;
  logic [3:0]    s_addr;
  logic [31:0]   s_wdata;
  logic [255:0]  s_rdata = '0;
  logic [7:0]    s_ack = '0;
  logic          trap;
  logic [11:0]   err_addr;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  logic [32:0] sb[$];

  always #10 clk50 = ~clk50;

  xperiph_bridge #(
    .DATA_W(32), .ADDR_W(12), .NSLV(8), .SLV_AW(4), .BASE(12'h100), .TO_CYC(15)
  ) dut (
    .clk50(clk50), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
    .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack), .trap(trap), .err_addr(err_addr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Completion monitor: every m_ack must match the oldest queued expectation.
  always @(negedge clk50) begin
    if (m_ack) begin
      if (sb.size() == 0) begin
        chk("extra_ack", 64'(m_ack), 64'd0);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        chk("sb_err", 64'(m_err), 64'(e[32]));
        chk("sb_rdata", 64'(m_rdata), 64'(e[31:0]));
      end
    end
  end

  // Cycle 0 issues the request; ack_k = 0 means the slave never answers.
  // A spurious ack on spur_slv is pulsed in cycles 1..2 and a stray request
  // is issued in cycle 2 when stray = 1.
  task automatic run_access(input logic [11:0] addr, input logic we, input logic [31:0] wdata,
                            input int ack_k, input int slv, input logic [31:0] data,
                            input logic [7:0] exp_sel, input int exp_cyc,
                            input logic exp_err, input logic [31:0] exp_rdata,
                            input int spur_slv, input logic stray);
    bit done;
    done = 0;
    @(posedge clk50); #1;
    m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata;
    sb.push_back({exp_err, exp_rdata});
    @(posedge clk50); #1;
    m_req = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      chk("s_sel", 64'(s_sel), 64'((cyc < exp_cyc) ? exp_sel : 8'h00));
      if (s_sel != 8'h00) begin
        chk("s_addr", 64'(s_addr), 64'(addr[3:0]));
        chk("s_we", 64'(s_we), 64'(we));
        if (we) chk("s_wdata", 64'(s_wdata), 64'(wdata));
      end
      if (m_ack) begin
        chk("ack_cycle", 64'(cyc), 64'(exp_cyc));
        s_ack = '0;
        m_req = 1'b0;
        done = 1;
        break;
      end
      s_ack = '0;
      if (cyc == ack_k) begin
        s_ack[slv] = 1'b1;
        s_rdata[slv*32 +: 32] = data;
      end
      if (spur_slv >= 0 && cyc <= 2) begin
        s_ack[spur_slv] = 1'b1;
        s_rdata[spur_slv*32 +: 32] = 32'hDEADBEEF;
      end
      m_req = 1'b0;
      if (stray && cyc == 2) begin
        m_req = 1'b1; m_we = 1'b0; m_addr = 12'h150;
      end
      @(posedge clk50); #1;
    end
    if (!done) chk("ack_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk50);
    #1;
    chk("rst_m_ack", 64'(m_ack), 64'd0);
    chk("rst_m_err", 64'(m_err), 64'd0);
    chk("rst_m_rdata", 64'(m_rdata), 64'd0);
    chk("rst_s_sel", 64'(s_sel), 64'd0);
    chk("rst_trap", 64'(trap), 64'd0);
    chk("rst_err_addr", 64'(err_addr), 64'd0);
    rst = 1'b0;

    run_access(12'h123, 1'b0, 32'h0, 1, 2, 32'hCAFE0001, 8'h04, 2, 1'b0, 32'hCAFE0001, -1, 1'b0);
    run_access(12'h170, 1'b1, 32'h5, 4, 7, 32'h12345678, 8'h80, 5, 1'b0, 32'h0, -1, 1'b0);
    run_access(12'h0FF, 1'b0, 32'h0, 0, 0, 32'h0, 8'h00, 1, 1'b1, 32'hFFFFFFFF, -1, 1'b0);
    run_access(12'h180, 1'b1, 32'h9, 0, 0, 32'h0, 8'h00, 1, 1'b1, 32'hFFFFFFFF, -1, 1'b0);
    @(posedge clk50); #1;
    chk("trap_set", 64'(trap), 64'd1);
    chk("err_addr_first", 64'(err_addr), 64'h0FF);

    run_access(12'h100, 1'b0, 32'h0, 0, 0, 32'h0, 8'h01, 16, 1'b1, 32'hFFFFFFFF, -1, 1'b0);
    run_access(12'h10A, 1'b0, 32'h0, 15, 0, 32'hA5A5_0F0F, 8'h01, 16, 1'b0, 32'hA5A5_0F0F, -1, 1'b0);
    chk("err_addr_kept", 64'(err_addr), 64'h0FF);

    run_access(12'h112, 1'b0, 32'h0, 4, 1, 32'h0000_1111, 8'h02, 5, 1'b0, 32'h0000_1111, 5, 1'b1);
    repeat (4) begin
      @(posedge clk50); #1;
      chk("no_stray_ack", 64'(m_ack), 64'd0);
    end

    @(posedge clk50); #1;
    m_req = 1'b1; m_we = 1'b0; m_addr = 12'h130;
    @(posedge clk50); #1;
    m_req = 1'b0;
    chk("pre_rst_sel", 64'(s_sel), 64'h08);
    @(posedge clk50); #1;
    rst = 1'b1;
    @(posedge clk50); #1;
    chk("midrst_s_sel", 64'(s_sel), 64'd0);
    chk("midrst_m_ack", 64'(m_ack), 64'd0);
    chk("midrst_trap", 64'(trap), 64'd0);
    chk("midrst_err_addr", 64'(err_addr), 64'd0);
    chk("midrst_s_addr", 64'(s_addr), 64'd0);
    chk("midrst_m_rdata", 64'(m_rdata), 64'd0);
    rst = 1'b0;
    run_access(12'h131, 1'b0, 32'h0, 2, 3, 32'h0000_1234, 8'h08, 3, 1'b0, 32'h0000_1234, -1, 1'b0);

    repeat (3) @(posedge clk50);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
